// File: rtl/costas_loop_filter.sv
// Costas carrier-recovery loop filter: per-sample BPSK/QPSK phase error, integrate-and-dump,
// shift-gain PI filter and lock detector, producing the NCO phase increment stream.
module costas_loop_filter #(
    parameter int                  WIDTH     = 16,
    parameter int                  OUT_WIDTH = 16,
    parameter int                  ACC_LEN   = 8,
    parameter int                  KP_SHIFT  = 4,
    parameter int                  KI_SHIFT  = 8,
    parameter logic [OUT_WIDTH-1:0] FREQ_INIT = 16'h4000,
    parameter bit                  QPSK      = 1'b0,
    parameter int                  LOCK_THR  = 64,
    parameter int                  LOCK_CNT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     sample_i,
    input  logic [WIDTH-1:0]     sample_q,
    input  logic                 sample_tvalid,
    input  logic                 loop_en,
    output logic [OUT_WIDTH-1:0] feedback_tdata,
    output logic                 feedback_tvalid,
    output logic                 locked
);

    localparam int EW    = WIDTH + 2;
    localparam int SHIFT = $clog2(ACC_LEN);
    localparam int AW    = EW + SHIFT;
    localparam int CW    = SHIFT + 1;
    localparam int SW    = ((EW > OUT_WIDTH) ? EW : OUT_WIDTH) + 2;
    localparam int LCW   = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [SW-1:0] x);
        if (x[SW-1:OUT_WIDTH-1] == '0 || x[SW-1:OUT_WIDTH-1] == '1)
            return x[OUT_WIDTH-1:0];
        else if (x[SW-1])
            return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    endfunction

    logic signed [EW-1:0] i_ext, q_ext, term_i, term_q, err;
    logic signed [AW-1:0] acc, acc_sum;
    logic signed [EW-1:0] dump_e;
    logic [CW-1:0]        cnt;
    logic                 last;

    // Two guard bits keep sgn(I)*Q - sgn(Q)*I exact, including negation of the most negative input.
    // NOTE: every always_comb output gets a value first so no path can infer a latch.
    always_comb begin
        i_ext   = EW'($signed(sample_i));
        q_ext   = EW'($signed(sample_q));
        term_i  = sample_i[WIDTH-1] ? -q_ext : q_ext;
        term_q  = sample_q[WIDTH-1] ? -i_ext : i_ext;
        err     = QPSK ? (term_i - term_q) : term_i;
        acc_sum = acc + AW'(err);
        dump_e  = EW'(acc_sum >>> SHIFT);
        last    = (cnt == CW'(ACC_LEN - 1));
    end

    logic                 s1_valid, s1_en;
    logic signed [EW-1:0] s1_e;

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            s1_valid <= 1'b0;
            s1_en    <= 1'b0;
            s1_e     <= '0;
        end else begin
            s1_valid <= 1'b0;
            if (sample_tvalid) begin
                if (last) begin
                    cnt      <= '0;
                    acc      <= '0;
                    s1_valid <= 1'b1;
                    s1_e     <= dump_e;
                    s1_en    <= loop_en;
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= acc_sum;
                end
            end
        end
    end

    logic signed [OUT_WIDTH-1:0] integ, integ_next, corr, corr_r;
    logic signed [SW-1:0]        int_sum, corr_sum;
    logic signed [EW-1:0]        e_abs;
    logic                        in_thr;

    always_comb begin
        int_sum    = SW'(integ) + SW'(s1_e >>> KI_SHIFT);
        integ_next = sat(int_sum);
        corr_sum   = SW'(integ_next) + SW'(s1_e >>> KP_SHIFT);
        corr       = sat(corr_sum);
        e_abs      = s1_e[EW-1] ? -s1_e : s1_e;
        in_thr     = (e_abs < EW'(LOCK_THR));
    end

    logic s2_valid, s2_en, s2_in_thr;

    // An open loop zeroes the correction, so the output stage always adds corr_r to FREQ_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ     <= '0;
            corr_r    <= '0;
            s2_valid  <= 1'b0;
            s2_en     <= 1'b0;
            s2_in_thr <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_en     <= s1_en;
                s2_in_thr <= in_thr;
                if (s1_en) begin
                    integ  <= integ_next;
                    corr_r <= corr;
                end else begin
                    integ  <= '0;
                    corr_r <= '0;
                end
            end
        end
    end

    logic [LCW-1:0] lock_cnt, lock_cnt_next;

    always_comb begin
        lock_cnt_next = '0;
        if (s2_in_thr)
            lock_cnt_next = (lock_cnt == LCW'(LOCK_CNT)) ? lock_cnt : lock_cnt + 1'b1;
    end

    // The feedback word wraps modulo 2^OUT_WIDTH rather than saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feedback_tdata  <= FREQ_INIT;
            feedback_tvalid <= 1'b0;
            lock_cnt        <= '0;
            locked          <= 1'b0;
        end else begin
            feedback_tvalid <= s2_valid;
            if (s2_valid) begin
                feedback_tdata <= FREQ_INIT + OUT_WIDTH'(corr_r);
                lock_cnt       <= lock_cnt_next;
                locked         <= (lock_cnt_next == LCW'(LOCK_CNT)) && s2_en;
            end
        end
    end

endmodule

// File: tb/tb_costas_loop_filter.sv
// Directed bench for costas_loop_filter: a default BPSK instance and a QPSK instance with ACC_LEN=1.
module tb_costas_loop_filter;

    logic        clk;
    logic        rst_n;
    logic [15:0] sample_i, sample_q;
    logic        tvalid_b, tvalid_q, loop_en;
    logic [15:0] fb_b, fb_q;
    logic        fbv_b, fbv_q, lk_b, lk_q;

    int          checks = 0;
    int          errors = 0;
    int          pulses;
    int          pulse_idx;
    logic [15:0] beat_data;
    logic        beat_lock;

    costas_loop_filter dut_b (
        .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .sample_q(sample_q),
        .sample_tvalid(tvalid_b), .loop_en(loop_en),
        .feedback_tdata(fb_b), .feedback_tvalid(fbv_b), .locked(lk_b)
    );

    costas_loop_filter #(.ACC_LEN(1), .QPSK(1'b1)) dut_q (
        .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .sample_q(sample_q),
        .sample_tvalid(tvalid_q), .loop_en(loop_en),
        .feedback_tdata(fb_q), .feedback_tvalid(fbv_q), .locked(lk_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic observe(input int idx);
        if (fbv_b === 1'b1) begin
            pulses++;
            pulse_idx = idx;
            beat_data = fb_b;
            beat_lock = lk_b;
        end
    endtask

    // n valid samples, each preceded by gap invalid cycles carrying junk; then 4 observed idle cycles.
    // pulse_idx 2 means the beat appeared in the cycle after the second edge following the last sample.
    task automatic send_window(input logic [15:0] i, input logic [15:0] q, input int n, input int gap);
        pulses = 0; pulse_idx = -1; beat_data = '0; beat_lock = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); observe(-1);
                sample_i = 16'hFC18; sample_q = 16'hEC78; tvalid_b = 1'b0;
            end
            @(negedge clk); observe(-1);
            sample_i = i; sample_q = q; tvalid_b = 1'b1;
        end
        for (int p = 0; p < 4; p++) begin
            @(negedge clk); observe(p);
            tvalid_b = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; tvalid_b = 1'b0; tvalid_q = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (fb_b !== 16'h4000) begin errors++; $display("FAIL reset_data got %h exp 4000", fb_b); end
        checks++; if (fbv_b !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", fbv_b); end
        checks++; if (lk_b !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", lk_b); end
        rst_n = 1'b1;
        @(negedge clk);
        send_window(16'd1000, 16'd256, 8, 0);
        checks++; if (fb_b !== 16'h4011) begin errors++; $display("FAIL reset_prep got %h exp 4011", fb_b); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (fb_b !== 16'h4000) begin errors++; $display("FAIL async_reset_data got %h exp 4000", fb_b); end
        checks++; if (fbv_b !== 1'b0) begin errors++; $display("FAIL async_reset_tvalid got %b exp 0", fbv_b); end
        checks++; if (lk_b !== 1'b0) begin errors++; $display("FAIL async_reset_locked got %b exp 0", lk_b); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin @(negedge clk); observe(c); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_pulses got %0d exp 0", pulses); end
        checks++; if (fb_b !== 16'h4000) begin errors++; $display("FAIL idle_data got %h exp 4000", fb_b); end
    endtask

    task automatic test_bpsk();
        apply_reset();
        send_window(16'd1000, 16'd256, 8, 0);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL bpsk_pos_pulses got %0d exp 1", pulses); end
        checks++; if (pulse_idx !== 2) begin errors++; $display("FAIL bpsk_latency got %0d exp 2", pulse_idx); end
        checks++; if (beat_data !== 16'h4011) begin errors++; $display("FAIL bpsk_pos_data got %h exp 4011", beat_data); end
        checks++; if (fb_b !== 16'h4011) begin errors++; $display("FAIL bpsk_hold got %h exp 4011", fb_b); end
        send_window(16'hFC18, 16'd256, 8, 0);
        checks++; if (beat_data !== 16'h3FF0) begin errors++; $display("FAIL bpsk_neg_data got %h exp 3ff0", beat_data); end
        apply_reset();
        send_window(16'hFFFF, 16'h8000, 8, 0);
        checks++; if (beat_data !== 16'h4880) begin errors++; $display("FAIL bpsk_min_q got %h exp 4880", beat_data); end
    endtask

    task automatic test_gapped();
        apply_reset();
        send_window(16'd1000, 16'd256, 7, 2);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL gap_early_pulse got %0d exp 0", pulses); end
        send_window(16'd1000, 16'd256, 1, 2);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL gap_pulses got %0d exp 1", pulses); end
        checks++; if (beat_data !== 16'h4011) begin errors++; $display("FAIL gap_data got %h exp 4011", beat_data); end
        checks++; if (pulse_idx !== 2) begin errors++; $display("FAIL gap_latency got %0d exp 2", pulse_idx); end
        send_window(16'd1000, 16'd256, 5, 2);
        apply_reset();
        send_window(16'd1000, 16'd256, 7, 2);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL partial_discard got %0d exp 0", pulses); end
        send_window(16'd1000, 16'd256, 1, 2);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL post_reset_pulses got %0d exp 1", pulses); end
        checks++; if (beat_data !== 16'h4011) begin errors++; $display("FAIL post_reset_data got %h exp 4011", beat_data); end
    endtask

    task automatic test_saturation();
        int bad = 0;
        apply_reset();
        for (int d = 1; d <= 260; d++) begin
            send_window(16'd1, 16'd32767, 8, 0);
            if (pulses != 1) bad++;
            if (d == 1) begin
                checks++; if (beat_data !== 16'h487E) begin errors++; $display("FAIL sat_dump1 got %h exp 487e", beat_data); end
            end
            if (d == 241) begin
                checks++; if (beat_data !== 16'hBF8E) begin errors++; $display("FAIL sat_dump241 got %h exp bf8e", beat_data); end
            end
            if (d == 260) begin
                checks++; if (beat_data !== 16'hBFFF) begin errors++; $display("FAIL sat_dump260 got %h exp bfff", beat_data); end
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL sat_pulse_count got %0d bad exp 0", bad); end
        send_window(16'hFFFF, 16'd32767, 8, 0);
        checks++; if (beat_data !== 16'hB77F) begin errors++; $display("FAIL sat_backoff got %h exp b77f", beat_data); end
    endtask

    task automatic test_lock();
        apply_reset();
        loop_en = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            send_window(16'd1000, 16'd63, 8, 0);
            checks++; if (beat_data !== 16'h4003) begin errors++; $display("FAIL lock_data%0d got %h exp 4003", d, beat_data); end
            checks++; if (beat_lock !== (d == 4)) begin errors++; $display("FAIL lock_flag%0d got %b exp %b", d, beat_lock, d == 4); end
        end
        send_window(16'd1000, 16'd64, 8, 0);
        checks++; if (beat_data !== 16'h4004) begin errors++; $display("FAIL lock_thr_data got %h exp 4004", beat_data); end
        checks++; if (beat_lock !== 1'b0) begin errors++; $display("FAIL lock_thr_flag got %b exp 0", beat_lock); end
        send_window(16'd1000, 16'd256, 8, 0);
        checks++; if (beat_data !== 16'h4011) begin errors++; $display("FAIL lock_e256 got %h exp 4011", beat_data); end
        loop_en = 1'b0;
        send_window(16'd1000, 16'd256, 8, 0);
        checks++; if (beat_data !== 16'h4000) begin errors++; $display("FAIL open_loop_data got %h exp 4000", beat_data); end
        checks++; if (beat_lock !== 1'b0) begin errors++; $display("FAIL open_loop_lock got %b exp 0", beat_lock); end
        loop_en = 1'b1;
        send_window(16'd1000, 16'd256, 8, 0);
        checks++; if (beat_data !== 16'h4011) begin errors++; $display("FAIL integ_cleared got %h exp 4011", beat_data); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_data [3] = '{16'h3FBD, 16'h3FB9, 16'h3FB5};
        apply_reset();
        sample_i = 16'hFC18;
        sample_q = 16'h07D0;
        for (int idx = 0; idx < 7; idx++) begin
            @(negedge clk);
            checks++;
            if (fbv_q !== (idx >= 3 && idx <= 5)) begin
                errors++; $display("FAIL qpsk_tvalid%0d got %b exp %b", idx, fbv_q, idx >= 3 && idx <= 5);
            end
            if (idx >= 3 && idx <= 5) begin
                checks++;
                if (fb_q !== exp_data[idx-3]) begin
                    errors++; $display("FAIL qpsk_data%0d got %h exp %h", idx, fb_q, exp_data[idx-3]);
                end
            end
            tvalid_q = (idx < 3);
        end
        sample_i = 16'd300;
        sample_q = 16'hFF38;
        tvalid_q = 1'b1;
        @(negedge clk); tvalid_q = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (fbv_q !== 1'b1) begin errors++; $display("FAIL qpsk_e100_tvalid got %b exp 1", fbv_q); end
        checks++; if (fb_q !== 16'h3FFA) begin errors++; $display("FAIL qpsk_e100_data got %h exp 3ffa", fb_q); end
    endtask

    initial begin
        rst_n = 1'b0;
        tvalid_b = 1'b0;
        tvalid_q = 1'b0;
        loop_en = 1'b1;
        sample_i = '0;
        sample_q = '0;
        test_reset();
        test_bpsk();
        test_gapped();
        test_saturation();
        test_lock();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
